// File: rtl/lm32_shifter_pipe_pkg.sv
// lm32_shifter_pipe_pkg: op encodings, fill modes and sizing helper shared by the shifter pipeline
package lm32_shifter_pipe_pkg;
  localparam int LM32_SHIFT_OP_W = 3;
  typedef enum logic [LM32_SHIFT_OP_W-1:0] {
    LM32_SHIFT_OP_SLL = 3'b000,
    LM32_SHIFT_OP_SRL = 3'b001,
    LM32_SHIFT_OP_SRA = 3'b010,
    LM32_SHIFT_OP_ROL = 3'b011,
    LM32_SHIFT_OP_ROR = 3'b100
  } lm32_shift_op_e;
  typedef enum logic [1:0] {
    FILL_ZERO = 2'd0,
    FILL_SIGN = 2'd1,
    FILL_ROT  = 2'd2
  } fill_e;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/lm32_shifter_pipe_if.sv
// lm32_shifter_pipe_if: operation request and result bundle of the pipelined shifter
interface lm32_shifter_pipe_if #(
  parameter int WIDTH   = 32,
  parameter int SHIFT_W = $clog2(WIDTH)
);
  import lm32_shifter_pipe_pkg::*;
  logic                       stall_i;
  logic                       flush_i;
  logic                       valid_i;
  logic [LM32_SHIFT_OP_W-1:0] op_i;
  logic [WIDTH-1:0]           data_i;
  logic [SHIFT_W-1:0]         amount_i;
  logic                       valid_o;
  logic [WIDTH-1:0]           result_o;
  logic                       carry_o;
  modport master (
    output stall_i, flush_i, valid_i, op_i, data_i, amount_i,
    input  valid_o, result_o, carry_o
  );
  modport slave (
    input  stall_i, flush_i, valid_i, op_i, data_i, amount_i,
    output valid_o, result_o, carry_o
  );
endinterface

// File: rtl/lm32_shifter_stage.sv
// lm32_shifter_stage: one partial right shift over amount bits [LO +: CHUNK_W] plus its register rank;
// the last stage undoes the input bit-reverse used for left operations.
module lm32_shifter_stage #(
  parameter int WIDTH   = 32,
  parameter int SHIFT_W = $clog2(WIDTH),
  parameter int LO      = 0,
  parameter int CHUNK_W = SHIFT_W,
  parameter bit IS_LAST = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHIFT_W-1:0] amount_i,
  input  logic [1:0]         fill_i,
  input  logic               rev_i,
  input  logic               carry_i,
  output logic               valid_o,
  output logic [WIDTH-1:0]   data_o,
  output logic [SHIFT_W-1:0] amount_o,
  output logic [1:0]         fill_o,
  output logic               rev_o,
  output logic               carry_o
);
  import lm32_shifter_pipe_pkg::*;
  logic [SHIFT_W-1:0] part;
  logic [WIDTH-1:0]   ext, shifted, nxt;
  always_comb begin
    part = '0;
    for (int i = 0; i < SHIFT_W; i++) part[i] = (i >= LO && i < LO + CHUNK_W) ? amount_i[i] : 1'b0;
    ext = fill_i == FILL_ROT ? data_i : fill_i == FILL_SIGN ? {WIDTH{data_i[WIDTH-1]}} : '0;
    shifted = WIDTH'({ext, data_i} >> part);
    for (int i = 0; i < WIDTH; i++) nxt[i] = (IS_LAST && rev_i) ? shifted[WIDTH-1-i] : shifted[i];
  end
  // flush only kills valid; data may carry stale values
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o  <= 1'b0;
      data_o   <= '0;
      amount_o <= '0;
      fill_o   <= '0;
      rev_o    <= 1'b0;
      carry_o  <= 1'b0;
    end else begin
      if (flush_i) valid_o <= 1'b0;
      else if (!stall_i) valid_o <= valid_i;
      if (!stall_i) begin
        data_o   <= nxt;
        amount_o <= amount_i ^ part;
        fill_o   <= fill_i;
        rev_o    <= rev_i;
        carry_o  <= carry_i;
      end
    end
  end
endmodule

// File: rtl/lm32_shifter_pipe.sv
// lm32_shifter_pipe: pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with carry-out, stall and flush.
// Left ops are bit-reversed into a common right shifter whose amount bits are split across STAGES.
module lm32_shifter_pipe
  import lm32_shifter_pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHIFT_W = $clog2(WIDTH),
  parameter int STAGES  = 2
) (
  input logic                clk_i,
  input logic                rst_n_i,
  lm32_shifter_pipe_if.slave bus
);
  localparam int C = ceil_div(SHIFT_W, STAGES);
  logic                         is_left, rsv, carry, unused_tail;
  logic [WIDTH-1:0]             x;
  logic [SHIFT_W-1:0]           amt, amt_m1;
  fill_e                        fill;
  logic [STAGES:0]              v, r, c;
  logic [STAGES:0][WIDTH-1:0]   d;
  logic [STAGES:0][SHIFT_W-1:0] a;
  logic [STAGES:0][1:0]         f;
  always_comb begin
    is_left = bus.op_i == LM32_SHIFT_OP_SLL || bus.op_i == LM32_SHIFT_OP_ROL;
    rsv = bus.op_i > LM32_SHIFT_OP_ROR;
    for (int i = 0; i < WIDTH; i++) x[i] = is_left ? bus.data_i[WIDTH-1-i] : bus.data_i[i];
    amt = rsv ? '0 : bus.amount_i;
    amt_m1 = amt - SHIFT_W'(1);
    fill = bus.op_i == LM32_SHIFT_OP_SRA ? FILL_SIGN :
           (bus.op_i == LM32_SHIFT_OP_ROL || bus.op_i == LM32_SHIFT_OP_ROR) ? FILL_ROT : FILL_ZERO;
    // on the reversed operand the left-op carry data[WIDTH-amt] also sits at x[amt-1]
    carry = amt != '0 && x[amt_m1];
  end
  assign v[0] = bus.valid_i;
  assign d[0] = x;
  assign a[0] = amt;
  assign f[0] = fill;
  assign r[0] = is_left;
  assign c[0] = carry;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = (k * C < SHIFT_W) ? k * C : SHIFT_W;
    localparam int HI = (k == STAGES - 1 || (k + 1) * C > SHIFT_W) ? SHIFT_W : (k + 1) * C;
    lm32_shifter_stage #(
      .WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .LO(LO), .CHUNK_W(HI - LO), .IS_LAST(k == STAGES - 1)
    ) u_stage (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(bus.stall_i), .flush_i(bus.flush_i),
      .valid_i(v[k]), .data_i(d[k]), .amount_i(a[k]), .fill_i(f[k]), .rev_i(r[k]), .carry_i(c[k]),
      .valid_o(v[k+1]), .data_o(d[k+1]), .amount_o(a[k+1]), .fill_o(f[k+1]), .rev_o(r[k+1]),
      .carry_o(c[k+1])
    );
  end
  assign unused_tail  = ^{a[STAGES], f[STAGES], r[STAGES]};
  assign bus.valid_o  = v[STAGES];
  assign bus.result_o = d[STAGES];
  assign bus.carry_o  = c[STAGES];
endmodule

// File: tb/tb_lm32_shifter_pipe.sv
// tb_lm32_shifter_pipe: directed checks of a 32-bit 2-stage shifter plus a 64-bit sweep over depths 1, 3 and 6
module tb_lm32_shifter_pipe;
  import lm32_shifter_pipe_pkg::*;
  localparam int SN = 48;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  lm32_shifter_pipe_if #(.WIDTH(32)) b32 ();
  lm32_shifter_pipe_if #(.WIDTH(64)) b64_1 ();
  lm32_shifter_pipe_if #(.WIDTH(64)) b64_3 ();
  lm32_shifter_pipe_if #(.WIDTH(64)) b64_6 ();
  lm32_shifter_pipe #(.WIDTH(32), .STAGES(2)) dut32  (.clk_i(clk), .rst_n_i(rst_n), .bus(b32));
  lm32_shifter_pipe #(.WIDTH(64), .STAGES(1)) dut64_1 (.clk_i(clk), .rst_n_i(rst_n), .bus(b64_1));
  lm32_shifter_pipe #(.WIDTH(64), .STAGES(3)) dut64_3 (.clk_i(clk), .rst_n_i(rst_n), .bus(b64_3));
  lm32_shifter_pipe #(.WIDTH(64), .STAGES(6)) dut64_6 (.clk_i(clk), .rst_n_i(rst_n), .bus(b64_6));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue32(input logic v, input logic [2:0] op, input logic [31:0] d, input logic [4:0] a);
    b32.valid_i = v;
    b32.op_i = op;
    b32.data_i = d;
    b32.amount_i = a;
  endtask

  task automatic drive64(input logic v, input logic [2:0] op, input logic [63:0] d, input logic [5:0] a);
    b64_1.valid_i = v; b64_1.op_i = op; b64_1.data_i = d; b64_1.amount_i = a;
    b64_3.valid_i = v; b64_3.op_i = op; b64_3.data_i = d; b64_3.amount_i = a;
    b64_6.valid_i = v; b64_6.op_i = op; b64_6.data_i = d; b64_6.amount_i = a;
  endtask

  function automatic logic [64:0] ref_shift(input logic [2:0] op, input logic [63:0] d, input int a);
    logic [63:0] r;
    logic c;
    r = d;
    c = 1'b0;
    case (op)
      3'd0: begin r = d << a; if (a != 0) c = d[64-a]; end
      3'd1: begin r = d >> a; if (a != 0) c = d[a-1]; end
      3'd2: begin r = $signed(d) >>> a; if (a != 0) c = d[a-1]; end
      3'd3: begin r = (d << a) | (d >> (64 - a)); if (a != 0) c = d[64-a]; end
      3'd4: begin r = (d >> a) | (d << (64 - a)); if (a != 0) c = d[a-1]; end
      default: ;
    endcase
    return {c, r};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({b32.valid_o, b32.result_o, b32.carry_o} !== 34'h0) begin
      errors++;
      $display("FAIL reset32: got v=%b r=%h c=%b, want v=0 r=00000000 c=0", b32.valid_o, b32.result_o, b32.carry_o);
    end
    checks++;
    if ({b64_1.valid_o, b64_3.valid_o, b64_6.valid_o, b64_3.result_o} !== 67'h0) begin
      errors++;
      $display("FAIL reset64: got v=%b%b%b r=%h, want v=000 r=0", b64_1.valid_o, b64_3.valid_o, b64_6.valid_o, b64_3.result_o);
    end
    #4 rst_n = 1'b1;
    step();
  endtask

  task automatic test_sra_srl();
    issue32(1'b1, LM32_SHIFT_OP_SRA, 32'h80000000, 5'd4);
    step();
    checks++;
    if (b32.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL sra_early: got v=%b, want v=0 after one cycle", b32.valid_o);
    end
    issue32(1'b1, LM32_SHIFT_OP_SRL, 32'h0000000F, 5'd4);
    step();
    checks++;
    if ({b32.valid_o, b32.result_o, b32.carry_o} !== {1'b1, 32'hF8000000, 1'b0}) begin
      errors++;
      $display("FAIL sra: got v=%b r=%h c=%b, want v=1 r=f8000000 c=0", b32.valid_o, b32.result_o, b32.carry_o);
    end
    issue32(1'b0, 3'd0, 32'h0, 5'd0);
    step();
    checks++;
    if ({b32.valid_o, b32.result_o, b32.carry_o} !== {1'b1, 32'h00000000, 1'b1}) begin
      errors++;
      $display("FAIL srl: got v=%b r=%h c=%b, want v=1 r=00000000 c=1", b32.valid_o, b32.result_o, b32.carry_o);
    end
    step();
    checks++;
    if (b32.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL srl_tail: got v=%b, want v=0", b32.valid_o);
    end
  endtask

  task automatic test_ops();
    logic [2:0]  ops [15] = '{3'd0, 3'd3, 3'd4, 3'd1, 3'd0, 3'd2, 3'd4, 3'd5, 3'd2, 3'd4, 3'd3, 3'd0, 3'd7, 3'd2, 3'd1};
    logic [31:0] ds  [15] = '{32'h00000001, 32'h80000001, 32'h00000001, 32'h12345678, 32'h12345678,
                              32'h87654321, 32'h12345678, 32'hDEADBEEF, 32'h80000000, 32'h12345678,
                              32'h12345678, 32'hF0000000, 32'h0000FFFF, 32'h7FFFFFF0, 32'h80000000};
    logic [4:0]  as  [15] = '{5'd31, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd31, 5'd4, 5'd8, 5'd4,
                              5'd16, 5'd4, 5'd31};
    logic [31:0] er  [15] = '{32'h80000000, 32'h00000003, 32'h80000000, 32'h12345678, 32'h12345678,
                              32'h87654321, 32'h12345678, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h81234567,
                              32'h34567812, 32'h00000000, 32'h0000FFFF, 32'h07FFFFFF, 32'h00000001};
    logic        ec  [15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                              1'b0, 1'b0, 1'b0};
    for (int i = 0; i <= 15; i++) begin
      if (i < 15) issue32(1'b1, ops[i], ds[i], as[i]);
      else issue32(1'b0, 3'd0, 32'h0, 5'd0);
      step();
      if (i >= 1) begin
        checks++;
        if ({b32.valid_o, b32.result_o, b32.carry_o} !== {1'b1, er[i-1], ec[i-1]}) begin
          errors++;
          $display("FAIL ops[%0d]: got v=%b r=%h c=%b, want v=1 r=%h c=%b", i - 1, b32.valid_o, b32.result_o, b32.carry_o, er[i-1], ec[i-1]);
        end
      end
    end
    step();
  endtask

  task automatic test_stall();
    issue32(1'b1, LM32_SHIFT_OP_SRL, 32'h000000F0, 5'd4);
    step();
    issue32(1'b1, LM32_SHIFT_OP_SLL, 32'h00000001, 5'd4);
    step();
    checks++;
    if ({b32.valid_o, b32.result_o, b32.carry_o} !== {1'b1, 32'h0000000F, 1'b0}) begin
      errors++;
      $display("FAIL stall_a: got v=%b r=%h c=%b, want v=1 r=0000000f c=0", b32.valid_o, b32.result_o, b32.carry_o);
    end
    issue32(1'b1, LM32_SHIFT_OP_ROR, 32'h00000003, 5'd1);
    step();
    checks++;
    if ({b32.valid_o, b32.result_o, b32.carry_o} !== {1'b1, 32'h00000010, 1'b0}) begin
      errors++;
      $display("FAIL stall_b: got v=%b r=%h c=%b, want v=1 r=00000010 c=0", b32.valid_o, b32.result_o, b32.carry_o);
    end
    b32.stall_i = 1'b1;
    issue32(1'b1, LM32_SHIFT_OP_SRA, 32'h80000000, 5'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({b32.valid_o, b32.result_o, b32.carry_o} !== {1'b1, 32'h00000010, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b r=%h c=%b, want v=1 r=00000010 c=0", i, b32.valid_o, b32.result_o, b32.carry_o);
      end
    end
    b32.stall_i = 1'b0;
    step();
    checks++;
    if ({b32.valid_o, b32.result_o, b32.carry_o} !== {1'b1, 32'h80000001, 1'b1}) begin
      errors++;
      $display("FAIL stall_c: got v=%b r=%h c=%b, want v=1 r=80000001 c=1", b32.valid_o, b32.result_o, b32.carry_o);
    end
    issue32(1'b0, 3'd0, 32'h0, 5'd0);
    step();
    checks++;
    if ({b32.valid_o, b32.result_o, b32.carry_o} !== {1'b1, 32'hC0000000, 1'b0}) begin
      errors++;
      $display("FAIL stall_d: got v=%b r=%h c=%b, want v=1 r=c0000000 c=0", b32.valid_o, b32.result_o, b32.carry_o);
    end
    step();
    checks++;
    if (b32.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_tail: got v=%b, want v=0 (no duplicate)", b32.valid_o);
    end
  endtask

  task automatic test_flush();
    issue32(1'b1, LM32_SHIFT_OP_SRL, 32'h0000FF00, 5'd8);
    step();
    issue32(1'b1, LM32_SHIFT_OP_SLL, 32'h00000005, 5'd3);
    step();
    checks++;
    if ({b32.valid_o, b32.result_o} !== {1'b1, 32'h000000FF}) begin
      errors++;
      $display("FAIL flush_pre: got v=%b r=%h, want v=1 r=000000ff", b32.valid_o, b32.result_o);
    end
    issue32(1'b0, 3'd0, 32'h0, 5'd0);
    b32.stall_i = 1'b1;
    b32.flush_i = 1'b1;
    step();
    checks++;
    if (b32.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_kill: got v=%b, want v=0", b32.valid_o);
    end
    b32.stall_i = 1'b0;
    b32.flush_i = 1'b0;
    step();
    checks++;
    if (b32.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_inflight: got v=%b r=%h, want v=0", b32.valid_o, b32.result_o);
    end
    issue32(1'b1, LM32_SHIFT_OP_ROL, 32'h0F000000, 5'd4);
    step();
    checks++;
    if (b32.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_post_early: got v=%b, want v=0", b32.valid_o);
    end
    issue32(1'b0, 3'd0, 32'h0, 5'd0);
    step();
    checks++;
    if ({b32.valid_o, b32.result_o, b32.carry_o} !== {1'b1, 32'hF0000000, 1'b0}) begin
      errors++;
      $display("FAIL flush_post: got v=%b r=%h c=%b, want v=1 r=f0000000 c=0", b32.valid_o, b32.result_o, b32.carry_o);
    end
    step();
  endtask

  task automatic test_async_reset();
    issue32(1'b1, LM32_SHIFT_OP_SLL, 32'h00000003, 5'd2);
    step();
    issue32(1'b1, LM32_SHIFT_OP_SRA, 32'h80000000, 5'd8);
    step();
    checks++;
    if ({b32.valid_o, b32.result_o, b32.carry_o} !== {1'b1, 32'h0000000C, 1'b0}) begin
      errors++;
      $display("FAIL arst_pre: got v=%b r=%h c=%b, want v=1 r=0000000c c=0", b32.valid_o, b32.result_o, b32.carry_o);
    end
    issue32(1'b0, 3'd0, 32'h0, 5'd0);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({b32.valid_o, b32.result_o, b32.carry_o} !== 34'h0) begin
      errors++;
      $display("FAIL arst_async: got v=%b r=%h c=%b, want v=0 r=00000000 c=0", b32.valid_o, b32.result_o, b32.carry_o);
    end
    #2 rst_n = 1'b1;
    step();
    checks++;
    if (b32.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL arst_lost: got v=%b, want v=0", b32.valid_o);
    end
    issue32(1'b1, LM32_SHIFT_OP_SRL, 32'h00000100, 5'd8);
    step();
    checks++;
    if (b32.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL arst_lat1: got v=%b, want v=0", b32.valid_o);
    end
    issue32(1'b0, 3'd0, 32'h0, 5'd0);
    step();
    checks++;
    if ({b32.valid_o, b32.result_o, b32.carry_o} !== {1'b1, 32'h00000001, 1'b0}) begin
      errors++;
      $display("FAIL arst_lat2: got v=%b r=%h c=%b, want v=1 r=00000001 c=0", b32.valid_o, b32.result_o, b32.carry_o);
    end
  endtask

  task automatic test_sweep();
    logic        ev [SN+6];
    logic [63:0] er [SN+6];
    logic        ec [SN+6];
    logic        v, ov, oc;
    logic [2:0]  op;
    logic [63:0] d, orr;
    logic [5:0]  a;
    int          lat, idx;
    for (int i = 0; i < SN + 6; i++) begin
      v = (i < SN) && ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      d = {$urandom, $urandom};
      a = (i % 8 == 0) ? 6'd0 : (i % 8 == 1) ? 6'd63 : 6'($urandom_range(0, 63));
      ev[i] = v;
      {ec[i], er[i]} = ref_shift(op, d, int'(a));
      drive64(v, op, d, a);
      step();
      for (int j = 0; j < 3; j++) begin
        lat = j == 0 ? 1 : j == 1 ? 3 : 6;
        ov  = j == 0 ? b64_1.valid_o  : j == 1 ? b64_3.valid_o  : b64_6.valid_o;
        orr = j == 0 ? b64_1.result_o : j == 1 ? b64_3.result_o : b64_6.result_o;
        oc  = j == 0 ? b64_1.carry_o  : j == 1 ? b64_3.carry_o  : b64_6.carry_o;
        idx = i + 1 - lat;
        if (idx >= 0) begin
          checks++;
          if (ov !== ev[idx] || (ev[idx] && {oc, orr} !== {ec[idx], er[idx]})) begin
            errors++;
            $display("FAIL sweep stages=%0d op#%0d: got v=%b r=%h c=%b, want v=%b r=%h c=%b", lat, idx, ov, orr, oc, ev[idx], er[idx], ec[idx]);
          end
        end
      end
    end
  endtask

  initial begin
    b32.stall_i = 1'b0;
    b32.flush_i = 1'b0;
    b64_1.stall_i = 1'b0; b64_1.flush_i = 1'b0;
    b64_3.stall_i = 1'b0; b64_3.flush_i = 1'b0;
    b64_6.stall_i = 1'b0; b64_6.flush_i = 1'b0;
    issue32(1'b0, 3'd0, 32'h0, 5'd0);
    drive64(1'b0, 3'd0, 64'h0, 6'd0);
    test_reset();
    test_sra_srl();
    test_ops();
    test_stall();
    test_flush();
    test_async_reset();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
